// File: rtl/clarvi_serial_alu.sv
// Byte-serial integer execute sequencer for the 64-bit core.
// Walks the byte-sliced register file one byte per cycle, carrying the add/sub chain
// between bytes and writing each result byte back as it is produced.
module clarvi_serial_alu #(
    parameter int unsigned XLEN_BYTES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        word,
    input  logic        use_imm,
    input  logic [11:0] imm,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [7:0]  rf_data_1,
    input  logic [7:0]  rf_data_2,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fetch_part,
    output logic        rs2_part_override,
    output logic [4:0]  fetch_register_1,
    output logic [4:0]  fetch_register_2,
    output logic [2:0]  write_part,
    output logic [4:0]  write_register,
    output logic [7:0]  write_data,
    output logic        write_enable
);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpSlt  = 3'd2;
    localparam logic [2:0] OpSltu = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpOr   = 3'd5;
    localparam logic [2:0] OpAnd  = 3'd6;
    localparam logic [2:0] OpMovb = 3'd7;

    localparam int unsigned LastPartInt = XLEN_BYTES - 1;
    localparam logic [2:0]  LastPart    = LastPartInt[2:0];

    typedef enum logic [1:0] {StIdle, StExec, StSetw, StDone} state_t;

    state_t      state_q;
    logic [2:0]  part_q;
    logic        carry_q;
    logic [2:0]  op_q;
    logic        word_q;
    logic        use_imm_q;
    logic [11:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic        sign_q;
    logic        lt_q;

    logic [8*XLEN_BYTES-1:0] imm_sx;
    logic [7:0]  b_byte;
    logic [8:0]  sum;
    logic [7:0]  result;
    logic        is_cmp;
    logic        is_sub;
    logic        sign_fill;
    logic        lt_next;

    // Byte datapath: operand select, carried add/sub chain and logic ops
    always_comb begin
        imm_sx    = {{(8*XLEN_BYTES-12){imm_q[11]}}, imm_q};
        b_byte    = use_imm_q ? imm_sx[{part_q, 3'b000} +: 8] : rf_data_2;
        is_cmp    = (op_q == OpSlt) || (op_q == OpSltu);
        is_sub    = (op_q == OpSub) || is_cmp;
        sum       = {1'b0, rf_data_1} + {1'b0, (is_sub ? ~b_byte : b_byte)} + {8'b0, carry_q};
        // Upper word bytes of W-forms come from the sign captured at byte 3
        sign_fill = word_q && ((op_q == OpAdd) || (op_q == OpSub)) && part_q[2];
        unique case (op_q)
            OpXor:   result = rf_data_1 ^ b_byte;
            OpOr:    result = rf_data_1 | b_byte;
            OpAnd:   result = rf_data_1 & b_byte;
            OpMovb:  result = b_byte;
            default: result = sum[7:0];
        endcase
        if (op_q == OpSltu) begin
            lt_next = ~sum[8];
        end else begin
            lt_next = (rf_data_1[7] ^ b_byte[7]) ? rf_data_1[7] : sum[7];
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        busy              = (state_q == StExec) || (state_q == StSetw);
        done              = (state_q == StDone);
        fetch_part        = part_q;
        write_part        = part_q;
        rs2_part_override = 1'b0;
        fetch_register_1  = rs1_q;
        fetch_register_2  = rs2_q;
        write_register    = rd_q;
        write_data        = 8'h00;
        write_enable      = 1'b0;
        if (state_q == StExec) begin
            write_data   = sign_fill ? {8{sign_q}} : result;
            write_enable = (rd_q != 5'd0) && !is_cmp;
        end else if (state_q == StSetw) begin
            write_data   = (part_q == 3'd0) ? {7'b0, lt_q} : 8'h00;
            write_enable = (rd_q != 5'd0);
        end
    end

    // Sequencer: latch request, step through bytes, deferred compare write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            part_q    <= 3'd0;
            carry_q   <= 1'b0;
            op_q      <= 3'd0;
            word_q    <= 1'b0;
            use_imm_q <= 1'b0;
            imm_q     <= 12'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            sign_q    <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q      <= op;
                        word_q    <= word;
                        use_imm_q <= use_imm;
                        imm_q     <= imm;
                        rs1_q     <= rs1;
                        rs2_q     <= rs2;
                        rd_q      <= rd;
                        part_q    <= 3'd0;
                        carry_q   <= (op == OpSub) || (op == OpSlt) || (op == OpSltu);
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    carry_q <= sum[8];
                    if (word_q && (part_q == 3'd3)) begin
                        sign_q <= result[7];
                    end
                    if (part_q == LastPart) begin
                        part_q <= 3'd0;
                        if (is_cmp) begin
                            lt_q    <= lt_next;
                            state_q <= StSetw;
                        end else begin
                            state_q <= StDone;
                        end
                    end else begin
                        part_q <= part_q + 3'd1;
                    end
                end
                StSetw: begin
                    if (part_q == LastPart) begin
                        part_q  <= 3'd0;
                        state_q <= StDone;
                    end else begin
                        part_q <= part_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
